// File: rtl/apb_ip_bridge.sv
// APB slave to simple IP-interface bridge: one APB transfer becomes a single
// read or write strobe towards the IP, then waits for the IP ack or a timeout.
module apb_ip_bridge #(
   parameter int ADDR_W  = 2,
   parameter int WDATA_W = 9,
   parameter int RDATA_W = 8,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        addr,
   input  logic               pwrite,
   input  logic               psel,
   input  logic               pen,
   input  logic [31:0]        pwdata,
   output logic [31:0]        prdata,
   output logic               pready,
   output logic               pslverr,
   output logic               bus2ip_clk,
   output logic [ADDR_W-1:0]  bus2ip_addr,
   output logic [WDATA_W-1:0] bus2ip_data,
   output logic               bus2ip_wr,
   output logic               bus2ip_rd,
   input  logic [RDATA_W-1:0] ip2bus_data,
   input  logic               ip2bus_rdack,
   input  logic               ip2bus_wrack
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

   state_t             state;
   state_t             state_next;
   logic [ADDR_W-1:0]  addr_q;
   logic [WDATA_W-1:0] data_q;
   logic               wr_q;
   logic [RDATA_W-1:0] rdata_q;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               err;
   logic               match_ack;
   logic               timeout_hit;
   logic               start;
   logic               unused_bits;

   assign bus2ip_clk  = clk;
   assign unused_bits = ^{addr, pwdata};

   // Only the ack that matches the latched direction counts; the other is ignored
   assign match_ack   = wr_q ? ip2bus_wrack : ip2bus_rdack;
   assign cnt_inc     = cnt + 1'b1;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);
   assign start       = (state == IDLE) && psel && pen;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (psel && pen) begin
               state_next = STROBE;
            end
         end
         STROBE: begin
            if (!psel) begin
               state_next = IDLE;
            end else if (match_ack) begin
               state_next = RESP;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (!psel) begin
               state_next = IDLE;
            end else if (match_ack || timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Transfer context: latched at the access edge, held until the next transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         cnt     <= '0;
         err     <= 1'b0;
      end else begin
         if (start) begin
            addr_q <= addr[ADDR_W-1:0];
            data_q <= pwdata[WDATA_W-1:0];
            wr_q   <= pwrite;
            cnt    <= '0;
            err    <= 1'b0;
         end
         if (state == WAIT) begin
            cnt <= cnt_inc;
         end
         if ((state == STROBE || state == WAIT) && psel && !wr_q && ip2bus_rdack) begin
            rdata_q <= ip2bus_data;
         end
         if (state == WAIT && psel && !match_ack && timeout_hit) begin
            err <= 1'b1;
         end
      end
   end

   // Outputs decode from registered state only; rst forces them low immediately
   always_comb begin
      prdata      = '0;
      pready      = 1'b0;
      pslverr     = 1'b0;
      bus2ip_wr   = 1'b0;
      bus2ip_rd   = 1'b0;
      bus2ip_addr = '0;
      bus2ip_data = '0;
      if (!rst) begin
         bus2ip_addr = addr_q;
         bus2ip_data = data_q;
         case (state)
            STROBE: begin
               bus2ip_wr = wr_q;
               bus2ip_rd = !wr_q;
            end
            RESP: begin
               pready  = 1'b1;
               pslverr = err;
               if (!err && !wr_q) begin
                  prdata = 32'(rdata_q);
               end
            end
            default: begin
               pready = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_ip_bridge.md
APB_IP_BRIDGE -- requirements
Module: apb_ip_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2: IP address width, 1..30.
REQ-002 The block SHALL have parameter WDATA_W, default 9: IP write data width, 1..32.
REQ-003 The block SHALL have parameter RDATA_W, default 8: IP read data width, 1..32.
REQ-004 The block SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles before the error response; 0 disables the timeout.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port addr, input, 32: APB address.
REQ-008 The block SHALL have ports pwrite, psel and pen, each input, 1: APB direction, select and enable.
REQ-009 The block SHALL have port pwdata, input, 32: APB write data.
REQ-010 The block SHALL have port prdata, output, 32: APB read data.
REQ-011 The block SHALL have ports pready and pslverr, each output, 1: transfer complete and transfer error.
REQ-012 The block SHALL have port bus2ip_clk, output, 1: equal to clk.
REQ-013 The block SHALL have port bus2ip_addr, output, ADDR_W: latched addr[ADDR_W-1:0].
REQ-014 The block SHALL have port bus2ip_data, output, WDATA_W: latched pwdata[WDATA_W-1:0].
REQ-015 The block SHALL have ports bus2ip_wr and bus2ip_rd, each output, 1: single-cycle write and read strobes.
REQ-016 The block SHALL have port ip2bus_data, input, RDATA_W: IP read data, valid in the cycle of ip2bus_rdack.
REQ-017 The block SHALL have ports ip2bus_rdack and ip2bus_wrack, each input, 1: IP read and write acknowledges.

Function
REQ-018 The FSM SHALL have the states IDLE, STROBE, WAIT and RESP, held in registers with no combinational feedback.
REQ-019 In IDLE with psel=1 and pen=1 (cycle T0), the block SHALL latch addr, pwdata and pwrite at the T0 clock edge and go to STROBE; in IDLE with psel=1 and pen=0, it SHALL stay in IDLE.
REQ-020 In STROBE, exactly one of bus2ip_wr or bus2ip_rd, selected by latched pwrite, SHALL be 1 for exactly one cycle; the FSM SHALL then go to WAIT, or go to RESP if the matching ack is present that same cycle.
REQ-021 In WAIT, the block SHALL go to RESP when the matching ack is seen: ip2bus_wrack for writes, ip2bus_rdack for reads.
REQ-022 The non-matching ack SHALL be ignored in all states, including when it coincides with the matching ack.
REQ-023 On a read ack, the block SHALL register ip2bus_data zero-extended to 32 bits.
REQ-024 A timeout counter SHALL clear on entry to STROBE and increment each WAIT cycle.
REQ-025 When TIMEOUT!=0 and the counter reaches TIMEOUT with no matching ack, the FSM SHALL go to RESP with the error flag set.
REQ-026 In RESP, pready SHALL be 1 for exactly one cycle, and pslverr SHALL equal the error flag.
REQ-027 In RESP, prdata SHALL be the captured data for a successful read, and 0 for writes or errors; the FSM SHALL go to IDLE next cycle.
REQ-028 Outside RESP, pready=0, pslverr=0 and prdata=0; prdata SHALL never be high-impedance.
REQ-029 Minimum latency SHALL be: T0 access, T1 strobe plus ack, T2 pready=1.
REQ-030 Each additional cycle of ack delay SHALL add one cycle of latency.
REQ-031 If psel=0 in STROBE or WAIT, the block SHALL abort to IDLE with no pready; a late ack for the aborted transfer SHALL be ignored.
REQ-032 Acks arriving in IDLE or RESP SHALL be ignored.
REQ-033 bus2ip_addr and bus2ip_data SHALL hold their latched values from STROBE through RESP.

Reset
REQ-034 While rst=1 the FSM SHALL be in IDLE.
REQ-035 While rst=1 the following SHALL all be 0: pready, pslverr, prdata, bus2ip_wr, bus2ip_rd, bus2ip_addr, bus2ip_data, the counter and the error flag.
REQ-036 Reset asserted mid-transfer SHALL abort it with no pready, and it SHALL take priority over all other inputs.

Verification
REQ-037 Write, addr=0x2, pwdata=0x1A5, wrack at T1: required bus2ip_wr=1 only at T1, bus2ip_addr=2, bus2ip_data=0x1A5, and at T2 pready=1, pslverr=0, prdata=0.
REQ-038 Read, addr=0x1, rdack after 3 WAIT cycles with ip2bus_data=0xC3: required bus2ip_rd pulses once, pready stays 0 until ack+1, then prdata=0x000000C3 with pready=1 for one cycle.
REQ-039 Write with no ack, TIMEOUT=16: required pready=1 and pslverr=1 exactly 17 cycles after STROBE, then IDLE.
REQ-040 Write with rdack asserted and no wrack, TIMEOUT=0: required the FSM remains in WAIT indefinitely; a later wrack completes the transfer normally.
REQ-041 psel dropped in WAIT, then ack: required no pready; a following read completes with its own data.
REQ-042 rst pulsed during WAIT: required all outputs 0 the next cycle, IDLE state, and a subsequent write succeeds.
